// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter bundle for uart_tx_queue: write port, FIFO status and the tx_start/tx_busy handshake.
// With UART_TXQ_FLUSH_EN defined the bundle also carries the producer's flush line.
interface uart_tx_queue_if #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic [LEVEL_W-1:0]    level;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_start;
    logic                  tx_busy;
    logic                  idle;
`ifdef UART_TXQ_FLUSH_EN
    logic                  flush;

    modport master (
        output wr_en, wr_data, tx_busy, flush,
        input  full, empty, level, overflow, tx_data, tx_start, idle
    );

    modport slave (
        input  wr_en, wr_data, tx_busy, flush,
        output full, empty, level, overflow, tx_data, tx_start, idle
    );
`else
    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, level, overflow, tx_data, tx_start, idle
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, level, overflow, tx_data, tx_start, idle
    );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO plus tx_start/tx_busy sequencer sitting directly in front of the uartTX transmitter.
// Optional feature: define UART_TXQ_FLUSH_EN to add bus.flush, which empties the FIFO without touching the FSM.
module uart_tx_queue #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_stateNext;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [LW-1:0]         r_level;
    logic [LW-1:0]         w_levelNext;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  r_txStart;
    logic                  w_txStartNext;
    logic [DATA_WIDTH-1:0] r_txData;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_wrAccept;
    logic                  w_wrReject;

`ifdef UART_TXQ_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    // A flush swallows a simultaneous write outright, so it can neither store nor flag overflow.
    assign w_wrAccept = bus.wr_en && !r_full && !w_flush;
    assign w_wrReject = bus.wr_en &&  r_full && !w_flush;

    always_comb begin
        w_stateNext   = r_state;
        w_txStartNext = r_txStart;
        w_pop         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!r_empty) begin
                    w_pop         = 1'b1;
                    w_txStartNext = 1'b1;
                    w_stateNext   = ST_START;
                end
            end
            ST_START: begin
                // Level handshake: keep requesting until the transmitter shows busy, then drop
                // before it can finish, so one frame never gets sent twice.
                if (bus.tx_busy) begin
                    w_txStartNext = 1'b0;
                    w_stateNext   = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_txStartNext = 1'b0;
                w_stateNext   = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_levelNext = r_level;
        if (w_flush) begin
            w_levelNext = '0;
        end else if (w_wrAccept && !w_pop) begin
            w_levelNext = r_level + LW'(1);
        end else if (!w_wrAccept && w_pop) begin
            w_levelNext = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_txStart <= 1'b0;
            r_txData  <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_txStart <= w_txStartNext;
            if (w_pop) begin
                r_txData <= r_mem[r_rdPtr];
            end
        end
    end

    // full/empty are registered copies of the next level so every status output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rdPtr <= r_wrPtr;
            end else if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_wrReject) begin
                r_overflow <= 1'b1;
            end
            r_level <= w_levelNext;
            r_full  <= (w_levelNext == LW'(DEPTH));
            r_empty <= (w_levelNext == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_mem[r_wrPtr] <= bus.wr_data;
        end
    end

    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
    assign bus.tx_data  = r_txData;
    assign bus.tx_start = r_txStart;
    assign bus.idle     = r_empty && (r_state == ST_IDLE) && !bus.tx_busy;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomised self-checking bench for uart_tx_queue, compared every cycle against a queue-based model.
// Build with UART_TXQ_FLUSH_EN defined to also exercise the flush input.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int DW    = 8;

    typedef enum int {CH_FREE, CH_OFFERED, CH_ON_WIRE} channel_e;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int testCount = 0;
    int failCount = 0;

    logic [DW-1:0] modelQ[$];
    logic          modelOvf;
    logic [DW-1:0] modelTxData;
    channel_e      channel;
    bit            flushIn;

    int xState;
    int xCnt;
    int xDelayMin;
    int xDelayMax;
    int xHoldMin;
    int xHoldMax;
    bit xStuck;

    logic [DW-1:0] emitted[$];
    logic          prevStart;
    int            peakLevel;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) busIf ();

    uart_tx_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (busIf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        testCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void resetModel();
        modelQ.delete();
        modelOvf    = 1'b0;
        modelTxData = '0;
        channel     = CH_FREE;
    endfunction

    // The model tracks only what the queue holds and whether the transmitter channel is free,
    // offered a byte, or carrying a frame.
    task automatic modelEdge();
        int preSize;
        bit accept;
        bit pop;
        if (!rst_n) begin
            resetModel();
            return;
        end
        preSize = modelQ.size();
        accept  = busIf.wr_en && !flushIn && (preSize < DEPTH);
        if (busIf.wr_en && !flushIn && (preSize >= DEPTH)) modelOvf = 1'b1;
        pop = (channel == CH_FREE) && (preSize > 0);
        case (channel)
            CH_FREE:    if (pop) channel = CH_OFFERED;
            CH_OFFERED: if (busIf.tx_busy) channel = CH_ON_WIRE;
            CH_ON_WIRE: if (!busIf.tx_busy) channel = CH_FREE;
            default:    channel = CH_FREE;
        endcase
        if (pop) modelTxData = modelQ.pop_front();
        if (accept) modelQ.push_back(busIf.wr_data);
        if (flushIn) modelQ.delete();
    endtask

    task automatic checkAll();
        checkOutput("level",    32'(busIf.level),    32'(modelQ.size()));
        checkOutput("empty",    32'(busIf.empty),    32'(modelQ.size() == 0));
        checkOutput("full",     32'(busIf.full),     32'(modelQ.size() == DEPTH));
        checkOutput("overflow", 32'(busIf.overflow), 32'(modelOvf));
        checkOutput("tx_start", 32'(busIf.tx_start), 32'(channel == CH_OFFERED));
        checkOutput("tx_data",  32'(busIf.tx_data),  32'(modelTxData));
        checkOutput("idle",     32'(busIf.idle),
                    32'((modelQ.size() == 0) && (channel == CH_FREE) && !busIf.tx_busy));
    endtask

    task automatic raiseBusy();
        busIf.tx_busy = 1'b1;
        xState        = 2;
        xCnt          = int'($urandom_range(xHoldMax, xHoldMin));
    endtask

    // Stand-in for uartTX: notices tx_start, raises busy after a delay, holds it for a frame.
    task automatic transmitterStep();
        case (xState)
            0: begin
                if (busIf.tx_start) begin
                    xCnt = int'($urandom_range(xDelayMax, xDelayMin));
                    if (xCnt == 0) raiseBusy();
                    else xState = 1;
                end
            end
            1: begin
                xCnt--;
                if (xCnt <= 0) raiseBusy();
            end
            default: begin
                if (!xStuck) begin
                    xCnt--;
                    if (xCnt <= 0) begin
                        busIf.tx_busy = 1'b0;
                        xState        = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input bit wr, input logic [DW-1:0] data, input bit fl);
        busIf.wr_en   = wr;
        busIf.wr_data = data;
`ifdef UART_TXQ_FLUSH_EN
        busIf.flush   = fl;
        flushIn       = fl;
`else
        flushIn       = 1'b0;
`endif
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
        if (busIf.tx_start && !prevStart) emitted.push_back(busIf.tx_data);
        prevStart = busIf.tx_start;
        if (int'(busIf.level) > peakLevel) peakLevel = int'(busIf.level);
        transmitterStep();
    endtask

    task automatic drainAll(input int budget);
        int n = 0;
        bit timedOut;
        while ((modelQ.size() != 0 || channel != CH_FREE || xState != 0) && n < budget) begin
            applyStimulus(1'b0, '0, 1'b0);
            n++;
        end
        timedOut = (modelQ.size() != 0 || channel != CH_FREE || xState != 0);
        checkOutput("drainTimeout", 32'(timedOut), 32'd0);
        checkOutput("idleAfterDrain", 32'(busIf.idle), 32'd1);
    endtask

    task automatic setTransmitter(input int dMin, input int dMax, input int hMin, input int hMax);
        xDelayMin = dMin;
        xDelayMax = dMax;
        xHoldMin  = hMin;
        xHoldMax  = hMax;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startsBefore;
        busIf.wr_en   = 1'b0;
        busIf.wr_data = '0;
        busIf.tx_busy = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
        busIf.flush   = 1'b0;
`endif
        flushIn   = 1'b0;
        xState    = 0;
        xCnt      = 0;
        xStuck    = 1'b0;
        prevStart = 1'b0;
        peakLevel = 0;
        resetModel();
        setTransmitter(1, 1, 20, 20);

        rst_n = 1'b0;
        repeat (3) applyStimulus(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        checkOutput("rstEmpty",    32'(busIf.empty),    32'd1);
        checkOutput("rstLevel",    32'(busIf.level),    32'd0);
        checkOutput("rstTxStart",  32'(busIf.tx_start), 32'd0);
        checkOutput("rstOverflow", 32'(busIf.overflow), 32'd0);
        checkOutput("rstIdle",     32'(busIf.idle),     32'd1);

        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("singleNotEmpty", 32'(busIf.empty),    32'd0);
        checkOutput("singleNoStart",  32'(busIf.tx_start), 32'd0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("singleStart",    32'(busIf.tx_start), 32'd1);
        checkOutput("singleData",     32'(busIf.tx_data),  32'hA5);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("singleHold",     32'(busIf.tx_start), 32'd1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("singleDrop",     32'(busIf.tx_start), 32'd0);
        drainAll(100);

        setTransmitter(0, 2, 2, 4);
        emitted.delete();
        peakLevel = 0;
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        drainAll(200);
        checkOutput("burstPeak",   32'(peakLevel),      32'd4);
        checkOutput("burstStarts", 32'(emitted.size()), 32'd5);
        for (int k = 0; k < 5; k++) checkOutput("burstOrder", 32'(emitted[k]), 32'(k + 1));

        setTransmitter(0, 0, 1, 1);
        emitted.delete();
        xStuck = 1'b1;
        for (int i = 1; i <= 18; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("fullLevel",   32'(busIf.level),    32'd16);
        checkOutput("fullFlag",    32'(busIf.full),     32'd1);
        checkOutput("fullOverflow",32'(busIf.overflow), 32'd1);
        xStuck = 1'b0;
        drainAll(2000);
        checkOutput("fullCount", 32'(emitted.size()), 32'd17);
        for (int k = 0; k < 17; k++) checkOutput("fullOrder", 32'(emitted[k]), 32'(k + 1));

        setTransmitter(0, 1, 1, 3);
        emitted.delete();
        begin
            int sent  = 0;
            int guard = 0;
            while (sent < 40 && guard < 4000) begin
                if (modelQ.size() < DEPTH && $urandom_range(9, 0) < 7) begin
                    applyStimulus(1'b1, 8'(sent ^ 8'h3C), 1'b0);
                    sent++;
                end else begin
                    applyStimulus(1'b0, '0, 1'b0);
                end
                guard++;
            end
            checkOutput("wrapWrites", 32'(sent), 32'd40);
        end
        drainAll(2000);
        checkOutput("wrapEmpty", 32'(busIf.empty),    32'd1);
        checkOutput("wrapCount", 32'(emitted.size()), 32'd40);
        for (int k = 0; k < 40; k++) checkOutput("wrapOrder", 32'(emitted[k]), 32'(k ^ 8'h3C));

        setTransmitter(0, 0, 30, 30);
        emitted.delete();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
        begin
            int n = 0;
            while (channel != CH_ON_WIRE && n < 50) begin
                applyStimulus(1'b0, '0, 1'b0);
                n++;
            end
            checkOutput("midReachedWait", 32'(channel == CH_ON_WIRE), 32'd1);
        end
        checkOutput("midQueued", 32'(busIf.level), 32'd3);
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput("midRstLevel",   32'(busIf.level),    32'd0);
        checkOutput("midRstEmpty",   32'(busIf.empty),    32'd1);
        checkOutput("midRstTxStart", 32'(busIf.tx_start), 32'd0);
        repeat (2) applyStimulus(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        startsBefore = emitted.size();
        repeat (60) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("midNoRestart", 32'(emitted.size() - startsBefore), 32'd0);
        checkOutput("midIdle",      32'(busIf.idle), 32'd1);

`ifdef UART_TXQ_FLUSH_EN
        setTransmitter(4, 4, 3, 3);
        emitted.delete();
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b1);
        checkOutput("flushLevel",     32'(busIf.level),    32'd0);
        checkOutput("flushStartHeld", 32'(busIf.tx_start), 32'd1);
        drainAll(200);
        checkOutput("flushCount", 32'(emitted.size()), 32'd1);
        checkOutput("flushByte",  32'(emitted[0]),     32'h11);
`endif

        setTransmitter(0, 3, 1, 6);
        for (int c = 0; c < 1500; c++) begin
            bit fl = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
            fl = ($urandom_range(49, 0) == 0);
`endif
            applyStimulus(1'($urandom_range(1, 0)), 8'($urandom), fl);
        end
        drainAll(3000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte FIFO and handshake sequencer directly upstream of the UART transmitter (uartTX).
- Accepts bytes from a producer in single-cycle write strobes and buffers them.
- Presents bytes one at a time on the transmitter's data_in/transmit inputs and paces them using its tx_busy output.
- Lets producers burst messages without polling the UART.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- DATA_WIDTH, 8, byte width; must match the transmitter data_in width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe; one byte accepted per cycle when not full
- wr_data  input  DATA_WIDTH  byte to enqueue
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH
- overflow  output  1  sticky: a write was attempted while full
- tx_data  output  DATA_WIDTH  to transmitter data_in
- tx_start  output  1  to transmitter transmit
- tx_busy  input  1  from transmitter tx_busy
- idle  output  1  FIFO empty, FSM in IDLE and tx_busy low

Behaviour:
- Reset (async, rst_n low):
  - Pointers and level clear to 0.
  - full=0, empty=1, overflow=0, tx_data=0, tx_start=0, FSM=IDLE.
  - idle=1 once tx_busy is low.
- Reset mid-transfer drops all queued bytes. tx_start deasserts immediately; the transmitter finishes its current frame on its own.
- All outputs except idle are registered. idle is combinational.
- Write:
  - Accepted when wr_en=1 and full=0, sampled at the start of the cycle.
  - wr_en=1 while full: byte is discarded, pointers unchanged, overflow set to 1 at the next edge. overflow stays 1 until reset.
- Read pointer and level:
  - rd_ptr advances only on the FSM IDLE->START transition.
  - Write and pop in the same cycle: level unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - full and empty are derived from level.
- FSM:
  - IDLE: if empty=0, load tx_data from the FIFO head, pop, set tx_start=1, go to START.
  - START: hold tx_start=1 and tx_data stable until tx_busy=1 is sampled. Then tx_start=0 on the next edge and go to WAIT_DONE.
    - Level handshake: tx_start is held until busy rises, never a blind single pulse.
    - tx_start must be low before the transmitter returns to its own idle state, so no double send.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE. tx_data is held throughout.
  - No timeout: if tx_busy never rises, the block stays in START indefinitely.
- Latency:
  - Write accepted at edge E into an empty FIFO: empty=0 after E; tx_start=1 after edge E+1.
  - Back-to-back bytes: next tx_start asserts 1 cycle after the IDLE entry that follows tx_busy falling.
- Writes during any FSM state are accepted subject to full. At most DEPTH bytes are buffered, plus one in flight in tx_data.
- tx_data changes only on IDLE->START.

Optional Feature:
- Macro UART_TXQ_FLUSH_EN adds input port flush (1 bit).
- With the macro defined, flush=1 at an edge:
  - Clears FIFO contents: pointers equal, level=0, empty=1.
  - Has priority over a simultaneous write, which is dropped without setting overflow.
  - Does not affect the FSM: a byte already in START or WAIT_DONE completes normally.
  - overflow is not cleared.
- Without the macro: no flush port, and the FIFO empties only by draining or reset.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low 3 cycles, then release with tx_busy=0.
  - Required: empty=1, level=0, tx_start=0, overflow=0, idle=1.
- Single byte:
  - Stimulus: write 0xA5 at edge E; transmitter model raises tx_busy 1 cycle after seeing tx_start, holds it 20 cycles.
  - Required: tx_start=1 after E+1 with tx_data=0xA5; tx_start drops one edge after busy is sampled high; idle=1 after busy falls.
- Burst and order:
  - Stimulus: write 0x01..0x05 on consecutive cycles.
  - Required: level peaks at 4 (one byte popped during the burst); bytes reach tx_data in order 0x01..0x05, each with exactly one tx_start episode.
- Full and overflow (DEPTH=16, tx_busy stuck high after first byte):
  - Stimulus: write 18 bytes.
  - Required: first byte in flight; 16 buffered, full=1, level=16; 18th write dropped, overflow=1; draining yields bytes 2..17 only.
- Wrap-around:
  - Stimulus: push and drain 40 bytes with pattern i^0x3C.
  - Required: all 40 emitted correctly with pointer wrap; empty=1 at end.
- Reset mid-frame:
  - Stimulus: assert rst_n low during WAIT_DONE with 3 bytes queued.
  - Required: level=0 and tx_start=0 immediately; no further tx_start after release. With UART_TXQ_FLUSH_EN, flush during START leaves the current byte completing and level=0.
